sha256_core: RTL and testbench
==============================

# sha256_core

Iterative SHA-224/SHA-256 compression core. It processes one pre-padded 512-bit block per operation at one round per clock and holds the 256-bit chaining state as its digest output. It sits below a bus/wrapper that handles message padding, block sequencing and SHA-224 truncation.

## Interface
Parameters: none.
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge
- `init`  in  1  one-cycle pulse: load IV selected by `mode`, hash `block` (first block of message)
- `next`  in  1  one-cycle pulse: hash `block` continuing from current digest
- `mode`  in  1  0 = SHA-224 IV, 1 = SHA-256 IV; sampled only when `init` is accepted
- `block`  in  512  message block, big-endian, word W0 = bits [511:480]; sampled when `init`/`next` is accepted
- `ready`  out  1  1 = idle, command accepted
- `digest`  out  256  chaining state H0..H7, H0 in bits [255:224]
- `digest_valid`  out  1  1 = `digest` is result of last completed operation

## Operation
- Reset (`reset_n`=0 at an edge): FSM→IDLE, `ready`=1, `digest_valid`=0, `digest`=0, round counter=0. Reset mid-operation aborts the operation with the same result.
- FSM states: IDLE, ROUNDS, DONE.
- IDLE, `init`=1: H←IV(`mode`), a..h←IV(`mode`), W window←`block`, t←0, `ready`←0, `digest_valid`←0, →ROUNDS.
  - SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - SHA-256 IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- IDLE, `next`=1 (and `init`=0): a..h←current H, W←`block`, same as above otherwise; `mode` ignored.
- `init` and `next` both 1: `init` wins.
- `init`/`next` while not IDLE: ignored, no effect on the operation in progress.
- ROUNDS: one FIPS 180-4 round per cycle using K[t], W[t]; W[t] for t≥16 = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16], all mod 2^32. After t=63 →DONE.
- DONE: H[i]←H[i]+{a..h}[i] mod 2^32, `digest_valid`←1, `ready`←1, →IDLE.
- `digest` always outputs all eight H words. In SHA-224 mode the wrapper uses bits [255:32]; bits [31:0] (H7) are still the full updated state word.
- `digest` holds its value between operations. `digest_valid` stays 1 until the next accepted command or reset.

## Timing
- Edge E0 samples `init`/`next` in IDLE. `ready` and `digest_valid` read 0 after E0.
- Rounds t=0..63 execute on edges E1..E64. The H update occurs at E65, where `ready`=1, `digest_valid`=1 and the new `digest` are all visible together.
- Latency: 65 cycles from the accepting edge to the result. A new command can be accepted at E66 at the earliest.
- `digest` is not updated during ROUNDS. It changes only at DONE, on `init` (loads IV), or on reset.

## Structure
- Package `sha256_pkg`: K[0..63] constant table, both IV sets, FSM state enum, and functions Σ0, Σ1, σ0, σ1, Ch, Maj.
- Sub-module `sha256_w_mem`: 16×32-bit sliding schedule window, loaded from `block`. It outputs W[t] and advances once per round.
- Top-level holds the FSM, t counter, a..h and H registers.

## Test plan
- "abc" single block (`block` = 61626380 00…00 00000018), `mode`=0, `init` → after 65 cycles `digest`=23097D22 3405D822 8642A477 BDA255B3 2AADBCE4 BDA0B3F7 E36C9DA7 D2DA082D, `digest_valid`=1.
- Same block, `mode`=1 → `digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block "abcdbcdecdef…nopq" (448 bits), `mode`=1:
  - `init` with block 1 → intermediate 85e655d6 417a1795 3363376a 624cde5c 76e09589 cac5f811 cc4b32c1 f20e533a.
  - `next` with block 2 (zeros, length 000001c0) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Command while busy: pulse `init` with a different block and `mode` at cycle 10 of an operation → result unchanged from the first scenario, completion still at E65.
- Reset mid-operation: `reset_n`=0 at cycle 30 → `ready`=1, `digest_valid`=0, `digest`=0; a subsequent "abc" run gives the correct result.
- Handshake check: `ready`=0 and `digest_valid`=0 at every sample from E0 to E64; both are 1 at E65.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and round helper functions for the SHA-224/256 compression core.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUNDS,
        ST_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'd63;

    localparam logic [255:0] IV_SHA224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [255:0] IV_SHA256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Ascending packed range so that K_TABLE[0] is the first listed constant.
    localparam logic [0:63][31:0] K_TABLE = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bigSigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bigSigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] smallSigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] smallSigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f,
                                           input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_w_mem.sv
// Sliding 16-word message schedule window; word 0 is always W[t] for the current round.
module sha256_w_mem
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [511:0] i_block,
    output logic [31:0]  o_w
);

    logic [31:0] r_window [0:15];
    logic [31:0] w_newWord;

    // Window holds W[t..t+15], so the word entering at the top is W[t+16].
    assign w_newWord = smallSigma1(r_window[14]) + r_window[9]
                     + smallSigma0(r_window[1]) + r_window[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= '0;
            end
        end else if (i_load) begin
            for (int i = 0; i < 16; i++) begin
                r_window[i] <= i_block[511 - 32*i -: 32];
            end
        end else if (i_advance) begin
            for (int i = 0; i < 15; i++) begin
                r_window[i] <= r_window[i+1];
            end
            r_window[15] <= w_newWord;
        end
    end

    assign o_w = r_window[0];

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-224/SHA-256 compression core: one round per clock, 65 cycles per 512-bit block.
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    state_t       r_state;
    state_t       w_nextState;
    logic [5:0]   r_round;
    logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    logic [255:0] r_digest;
    logic         r_digestValid;

    logic         w_start;
    logic         w_advance;
    logic [255:0] w_startState;
    logic [31:0]  w_w;
    logic [31:0]  w_t1;
    logic [31:0]  w_t2;

    assign w_start      = (r_state == ST_IDLE) && (init || next);
    assign w_advance    = (r_state == ST_ROUNDS);
    // init takes priority over next and is the only path that loads an IV.
    assign w_startState = init ? (mode ? IV_SHA256 : IV_SHA224) : r_digest;

    sha256_w_mem u_wMem (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_start),
        .i_advance (w_advance),
        .i_block   (block),
        .o_w       (w_w)
    );

    assign w_t1 = r_h + bigSigma1(r_e) + choose(r_e, r_f, r_g) + K_TABLE[r_round] + w_w;
    assign w_t2 = bigSigma0(r_a) + majority(r_a, r_b, r_c);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start) w_nextState = ST_ROUNDS;
            ST_ROUNDS: if (r_round == LAST_ROUND) w_nextState = ST_DONE;
            ST_DONE:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_round       <= '0;
            r_digest      <= '0;
            r_digestValid <= 1'b0;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_startState;
                        r_digest      <= w_startState;
                        r_round       <= '0;
                        r_digestValid <= 1'b0;
                    end
                end
                ST_ROUNDS: begin
                    r_h     <= r_g;
                    r_g     <= r_f;
                    r_f     <= r_e;
                    r_e     <= r_d + w_t1;
                    r_d     <= r_c;
                    r_c     <= r_b;
                    r_b     <= r_a;
                    r_a     <= w_t1 + w_t2;
                    r_round <= r_round + 6'd1;
                end
                ST_DONE: begin
                    r_digest <= {r_digest[255:224] + r_a, r_digest[223:192] + r_b,
                                 r_digest[191:160] + r_c, r_digest[159:128] + r_d,
                                 r_digest[127:96]  + r_e, r_digest[95:64]   + r_f,
                                 r_digest[63:32]   + r_g, r_digest[31:0]    + r_h};
                    r_digestValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready        = (r_state == ST_IDLE);
    assign digest       = r_digest;
    assign digest_valid = r_digestValid;

endmodule

// File: tb/tb_sha256_core.sv
// Directed test of the SHA-224/256 compression core against FIPS 180-4 reference digests.
module tb_sha256_core;

    localparam logic [511:0] BLOCK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLOCK_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLOCK_TWO_2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] IV_224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [223:0] ABC_224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
    localparam logic [255:0] ABC_256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_MID = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] TWO_FIN = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic         mode = 1'b0;
    logic [511:0] block = '0;
    logic         ready;
    logic [255:0] digest;
    logic         digest_valid;

    int errorCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    sha256_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .init         (init),
        .next         (next),
        .mode         (mode),
        .block        (block),
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    // Every helper returns 1 time unit after a rising edge so sampling stays clear of the edge.
    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the command for one edge (E0) and then withdraws it.
    task automatic issueCommand(input logic doInit, input logic doNext, input logic cmdMode,
                                input logic [511:0] cmdBlock);
        init  = doInit;
        next  = doNext;
        mode  = cmdMode;
        block = cmdBlock;
        waitEdges(1);
        init  = 1'b0;
        next  = 1'b0;
        mode  = 1'b0;
        block = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        waitEdges(2);
        checkCount++;
        if (ready !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
        checkCount++;
        if (digest_valid !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_valid: got %b expected 0", digest_valid);
        end
        checkCount++;
        if (digest !== 256'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_digest: got %h expected 0", digest);
        end
        reset_n = 1'b1;
        waitEdges(1);
    endtask

    // SHA-224 "abc" with the handshake watched at every sample from E0 through E65.
    task automatic test_sha224_abc();
        issueCommand(1'b1, 1'b0, 1'b0, BLOCK_ABC);
        for (int k = 0; k <= 64; k++) begin
            if (k > 0) waitEdges(1);
            checkCount++;
            if ({ready, digest_valid} !== 2'b00) begin
                errorCount++;
                $display("[TB] FAIL busy_handshake E%0d: got ready,valid=%b%b expected 00",
                         k, ready, digest_valid);
            end
            checkCount++;
            if (digest !== IV_224) begin
                errorCount++;
                $display("[TB] FAIL digest_held_iv224 E%0d: got %h expected %h", k, digest, IV_224);
            end
        end
        waitEdges(1);
        checkCount++;
        if ({ready, digest_valid} !== 2'b11) begin
            errorCount++;
            $display("[TB] FAIL done_handshake_224: got ready,valid=%b%b expected 11",
                     ready, digest_valid);
        end
        // H7 is not part of the published SHA-224 digest, so only the wrapper-visible words are compared.
        checkCount++;
        if (digest[255:32] !== ABC_224) begin
            errorCount++;
            $display("[TB] FAIL sha224_abc: got %h expected %h", digest[255:32], ABC_224);
        end
    endtask

    task automatic test_sha256_abc();
        issueCommand(1'b1, 1'b0, 1'b1, BLOCK_ABC);
        waitEdges(64);
        checkCount++;
        if (ready !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL not_ready_at_E64: got %b expected 0", ready);
        end
        waitEdges(1);
        checkCount++;
        if ({ready, digest_valid} !== 2'b11) begin
            errorCount++;
            $display("[TB] FAIL done_handshake_256: got ready,valid=%b%b expected 11",
                     ready, digest_valid);
        end
        checkCount++;
        if (digest !== ABC_256) begin
            errorCount++;
            $display("[TB] FAIL sha256_abc: got %h expected %h", digest, ABC_256);
        end
        waitEdges(5);
        checkCount++;
        if ({digest_valid, digest} !== {1'b1, ABC_256}) begin
            errorCount++;
            $display("[TB] FAIL idle_hold: got valid=%b %h expected valid=1 %h",
                     digest_valid, digest, ABC_256);
        end
    endtask

    task automatic test_two_block();
        issueCommand(1'b1, 1'b0, 1'b1, BLOCK_TWO_1);
        waitEdges(65);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b11, TWO_MID}) begin
            errorCount++;
            $display("[TB] FAIL two_block_mid: got r/v=%b%b %h expected 11 %h",
                     ready, digest_valid, digest, TWO_MID);
        end
        // mode=0 here must be ignored, and next must not reload an IV.
        issueCommand(1'b0, 1'b1, 1'b0, BLOCK_TWO_2);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b00, TWO_MID}) begin
            errorCount++;
            $display("[TB] FAIL next_accept: got r/v=%b%b %h expected 00 %h",
                     ready, digest_valid, digest, TWO_MID);
        end
        waitEdges(65);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b11, TWO_FIN}) begin
            errorCount++;
            $display("[TB] FAIL two_block_final: got r/v=%b%b %h expected 11 %h",
                     ready, digest_valid, digest, TWO_FIN);
        end
    endtask

    task automatic test_busy_command();
        issueCommand(1'b1, 1'b0, 1'b1, BLOCK_ABC);
        waitEdges(10);
        init  = 1'b1;
        next  = 1'b1;
        mode  = 1'b0;
        block = BLOCK_TWO_1;
        waitEdges(1);
        init  = 1'b0;
        next  = 1'b0;
        block = '0;
        waitEdges(53);
        checkCount++;
        if (ready !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL busy_not_ready_E64: got %b expected 0", ready);
        end
        waitEdges(1);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b11, ABC_256}) begin
            errorCount++;
            $display("[TB] FAIL busy_ignored: got r/v=%b%b %h expected 11 %h",
                     ready, digest_valid, digest, ABC_256);
        end
    endtask

    // Both pulses at once: init must win, so the result is SHA-224 rather than a continuation.
    task automatic test_init_priority();
        issueCommand(1'b1, 1'b1, 1'b0, BLOCK_ABC);
        waitEdges(65);
        checkCount++;
        if (digest[255:32] !== ABC_224) begin
            errorCount++;
            $display("[TB] FAIL init_priority: got %h expected %h", digest[255:32], ABC_224);
        end
    endtask

    task automatic test_reset_mid();
        issueCommand(1'b1, 1'b0, 1'b1, BLOCK_ABC);
        waitEdges(30);
        reset_n = 1'b0;
        waitEdges(1);
        reset_n = 1'b1;
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b10, 256'h0}) begin
            errorCount++;
            $display("[TB] FAIL reset_mid: got r/v=%b%b %h expected 10 0",
                     ready, digest_valid, digest);
        end
        waitEdges(40);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b10, 256'h0}) begin
            errorCount++;
            $display("[TB] FAIL reset_mid_quiet: got r/v=%b%b %h expected 10 0",
                     ready, digest_valid, digest);
        end
        issueCommand(1'b1, 1'b0, 1'b1, BLOCK_ABC);
        waitEdges(65);
        checkCount++;
        if ({ready, digest_valid, digest} !== {2'b11, ABC_256}) begin
            errorCount++;
            $display("[TB] FAIL rerun_after_reset: got r/v=%b%b %h expected 11 %h",
                     ready, digest_valid, digest, ABC_256);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sha224_abc();
        test_sha256_abc();
        test_two_block();
        test_busy_command();
        test_init_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
